// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: queues ALU commands in a DEPTH-entry FIFO and presents the head
// to an external combinational 8-bit ALU. Each result is captured into a
// registered output stage with its own valid/ready handshake.
// Optional feature macro: ALU_OVF_EN adds the res_ovf output, which is the
// signed overflow flag registered together with res_out.
//
// Handshake rule for both ports: a transfer happens on a rising edge where
// valid && ready are both high. A producer holding valid keeps its payload
// stable until the transfer, and ready never depends on the valid of the same
// port. in_ready is derived from the occupancy only.
module alu_cmd_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [7:0]               in_a,
    input  logic [7:0]               in_b,
    input  logic                     in_cin,
    input  logic [1:0]               in_sel,
    output logic [7:0]               alu_a,
    output logic [7:0]               alu_b,
    output logic                     alu_cin,
    output logic [1:0]               alu_sel,
    input  logic [7:0]               alu_out,
    input  logic                     alu_cout,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [7:0]               res_out,
    output logic                     res_cout,
`ifdef ALU_OVF_EN
    output logic                     res_ovf,
`endif
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    // Command storage, one array per field.
    logic [7:0]    mem_a   [DEPTH];
    logic [7:0]    mem_b   [DEPTH];
    logic          mem_cin [DEPTH];
    logic [1:0]    mem_sel [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    logic          not_empty;

    // Push and pop qualifiers. A pop happens whenever there is a head command
    // and the output register is free or being drained this cycle. Full blocks
    // pushes even if a pop frees a slot in the same cycle.
    always_comb begin
        not_empty = (count != '0);
        in_ready  = (count < FULL_COUNT);
        push      = in_valid && in_ready;
        pop       = not_empty && (!res_valid || res_ready);
    end

    // Present the head command to the ALU; drive zeros while the queue is empty.
    always_comb begin
        alu_a   = 8'h00;
        alu_b   = 8'h00;
        alu_cin = 1'b0;
        alu_sel = 2'b00;
        if (not_empty) begin
            alu_a   = mem_a[rd_ptr];
            alu_b   = mem_b[rd_ptr];
            alu_cin = mem_cin[rd_ptr];
            alu_sel = mem_sel[rd_ptr];
        end
    end

    // Write accepted commands into the storage array (data needs no reset).
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr]   <= in_a;
            mem_b[wr_ptr]   <= in_b;
            mem_cin[wr_ptr] <= in_cin;
            mem_sel[wr_ptr] <= in_sel;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef ALU_OVF_EN
    logic ovf_next;

    // Signed overflow of the head operation: add overflows when the operands
    // share a sign that the result lacks, sub when the signs differ and the
    // result sign flips away from a. Logic ops never overflow.
    always_comb begin
        ovf_next = 1'b0;
        case (alu_sel)
            2'b00:   ovf_next = (alu_a[7] == alu_b[7]) && (alu_out[7] != alu_a[7]);
            2'b01:   ovf_next = (alu_a[7] != alu_b[7]) && (alu_out[7] != alu_a[7]);
            default: ovf_next = 1'b0;
        endcase
    end

    // Overflow flag is captured on the same edge as res_out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_ovf <= 1'b0;
        end else if (pop) begin
            res_ovf <= ovf_next;
        end
    end
`endif

    // Output register: capture the ALU result on pop; otherwise drop valid once
    // the consumer takes it. Data holds its last value when not capturing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_out   <= 8'h00;
            res_cout  <= 1'b0;
        end else if (pop) begin
            res_valid <= 1'b1;
            res_out   <= alu_out;
            // Carry/borrow only has meaning for add and sub.
            res_cout  <= alu_sel[1] ? 1'b0 : alu_cout;
        end else if (res_valid && res_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_cmd_fifo.sv
// tb_alu_cmd_fifo: directed bench for alu_cmd_fifo (DEPTH=4) with a
// behavioural 8-bit ALU attached to the alu_* ports. Define ALU_OVF_EN to
// also exercise the res_ovf output.
module tb_alu_cmd_fifo;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       in_cin;
    logic [1:0] in_sel;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic       alu_cin;
    logic [1:0] alu_sel;
    logic [7:0] alu_out;
    logic       alu_cout;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_out;
    logic       res_cout;
`ifdef ALU_OVF_EN
    logic       res_ovf;
`endif
    logic [2:0] count;

    int n_assert;
    int n_fail;

    alu_cmd_fifo #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sel    (in_sel),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_cin   (alu_cin),
        .alu_sel   (alu_sel),
        .alu_out   (alu_out),
        .alu_cout  (alu_cout),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_out   (res_out),
        .res_cout  (res_cout),
`ifdef ALU_OVF_EN
        .res_ovf   (res_ovf),
`endif
        .count     (count)
    );

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream ALU. Logic ops drive carry high so the block must mask it.
    always_comb begin
        logic [8:0] r;
        r = 9'h000;
        case (alu_sel)
            2'b00:   r = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_cin};
            2'b01:   r = {1'b0, alu_a} - {1'b0, alu_b} - {8'h00, alu_cin};
            2'b10:   r = {1'b1, alu_a & alu_b};
            default: r = {1'b1, alu_a | alu_b};
        endcase
        alu_out  = r[7:0];
        alu_cout = r[8];
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] b,
                         input logic cin, input logic [1:0] sel);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_sel   = sel;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_a     = 8'h00;
        in_b     = 8'h00;
        in_cin   = 1'b0;
        in_sel   = 2'b00;
    endtask

    // One command through an empty block with res_ready=1.
    task automatic run_single(input string tag, input logic [7:0] a, input logic [7:0] b,
                              input logic cin, input logic [1:0] sel,
                              input logic [7:0] exp_out, input logic exp_cout);
        drive(a, b, cin, sel);
        tick();
        idle();
        chk1({tag, "_valid_lat0"}, res_valid, 1'b0);
        tick();
        chk1({tag, "_valid"}, res_valid, 1'b1);
        chk8({tag, "_out"}, res_out, exp_out);
        chk1({tag, "_cout"}, res_cout, exp_cout);
        tick();
        chk1({tag, "_valid_clr"}, res_valid, 1'b0);
        chk8({tag, "_out_hold"}, res_out, exp_out);
    endtask

`ifdef ALU_OVF_EN
    task automatic run_ovf(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [1:0] sel, input logic [7:0] exp_out,
                           input logic exp_ovf);
        drive(a, b, 1'b0, sel);
        tick();
        idle();
        tick();
        chk8({tag, "_out"}, res_out, exp_out);
        chk1({tag, "_ovf"}, res_ovf, exp_ovf);
        tick();
    endtask
`endif

    initial begin
        logic [7:0] e;
        n_assert  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        res_ready = 1'b0;
        idle();

        // Reset state.
        #1;
        chk8("rst_count", 8'(count), 8'd0);
        chk1("rst_valid", res_valid, 1'b0);
        chk8("rst_out", res_out, 8'h00);
        chk1("rst_cout", res_cout, 1'b0);
        chk8("rst_alu_a", alu_a, 8'h00);
        tick();
        rst = 1'b0;
        tick();
        chk1("post_rst_in_ready", in_ready, 1'b1);

        // Single add: FF + 01 + 1 = 0x101; head visible on ALU after push.
        res_ready = 1'b1;
        drive(8'hFF, 8'h01, 1'b1, 2'b00);
        tick();
        idle();
        chk8("add_count1", 8'(count), 8'd1);
        chk8("add_alu_a", alu_a, 8'hFF);
        chk8("add_alu_b", alu_b, 8'h01);
        chk1("add_alu_cin", alu_cin, 1'b1);
        chk1("add_valid_lat0", res_valid, 1'b0);
        tick();
        chk1("add_valid", res_valid, 1'b1);
        chk8("add_out", res_out, 8'h01);
        chk1("add_cout", res_cout, 1'b1);
        chk8("add_count0", 8'(count), 8'd0);
        chk8("add_alu_a_empty", alu_a, 8'h00);
        tick();
        chk1("add_valid_clr", res_valid, 1'b0);
        chk8("add_out_hold", res_out, 8'h01);

        // Sub with borrow, AND and OR with carry masked.
        run_single("sub", 8'h00, 8'h01, 1'b0, 2'b01, 8'hFF, 1'b1);
        run_single("and", 8'hF0, 8'h3C, 1'b0, 2'b10, 8'h30, 1'b0);
        run_single("or",  8'h0F, 8'hA0, 1'b1, 2'b11, 8'hAF, 1'b0);
        run_single("subc", 8'h50, 8'h20, 1'b1, 2'b01, 8'h2F, 1'b0);

        // Backpressure: five adds with res_ready low -> 1 held + 4 queued.
        res_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive(8'h10 + 8'(k), 8'h20, 1'b0, 2'b00);
            tick();
        end
        chk8("full_count", 8'(count), 8'd4);
        chk1("full_in_ready", in_ready, 1'b0);
        chk1("full_valid", res_valid, 1'b1);
        chk8("full_out", res_out, 8'h30);
        // Extra command while full must not enter.
        drive(8'hEE, 8'h11, 1'b0, 2'b00);
        tick();
        chk8("full_hold_count", 8'(count), 8'd4);
        chk8("full_hold_out", res_out, 8'h30);
        // Release: a pop the same cycle still must not let the extra one in.
        res_ready = 1'b1;
        tick();
        idle();
        chk8("drain_count3", 8'(count), 8'd3);
        chk8("drain_out1", res_out, 8'h31);
        for (int j = 2; j < 5; j++) begin
            tick();
            chk1("drain_valid", res_valid, 1'b1);
            chk8("drain_out", res_out, 8'h30 + 8'(j));
            chk8("drain_count", 8'(count), 8'(4 - j));
        end
        tick();
        chk1("drain_valid_clr", res_valid, 1'b0);
        chk8("drain_out_hold", res_out, 8'h34);

        // Streaming: 20 back-to-back adds, one result per cycle.
        for (int c = 1; c <= 21; c++) begin
            if (c <= 20) begin
                drive(8'(c - 1), 8'h05, 1'(c - 1), 2'b00);
            end else begin
                idle();
            end
            tick();
            chk8("stream_count", 8'(count), (c <= 20) ? 8'd1 : 8'd0);
            if (c == 1) begin
                chk1("stream_valid_first", res_valid, 1'b0);
            end else begin
                e = 8'(c - 2) + 8'h05 + 8'((c - 2) % 2);
                chk1("stream_valid", res_valid, 1'b1);
                chk8("stream_out", res_out, e);
            end
        end
        idle();
        tick();
        chk1("stream_valid_clr", res_valid, 1'b0);

        // Reset mid-operation with count=3 and a pending result.
        res_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(8'(k + 1), 8'h00, 1'b0, 2'b00);
            tick();
        end
        idle();
        chk8("pre_rst_count", 8'(count), 8'd3);
        chk1("pre_rst_valid", res_valid, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk8("arst_count", 8'(count), 8'd0);
        chk1("arst_valid", res_valid, 1'b0);
        chk8("arst_out", res_out, 8'h00);
        chk1("arst_in_ready", in_ready, 1'b1);
        chk8("arst_alu_a", alu_a, 8'h00);
        #1;
        rst = 1'b0;
        tick();
        chk1("rel_in_ready", in_ready, 1'b1);
        chk1("rel_valid", res_valid, 1'b0);
        res_ready = 1'b1;
        tick();
        tick();
        chk1("rel_no_stale", res_valid, 1'b0);
        chk8("rel_count", 8'(count), 8'd0);
        run_single("after_rst", 8'h05, 8'h50, 1'b0, 2'b11, 8'h55, 1'b0);

`ifdef ALU_OVF_EN
        run_ovf("ovf_add", 8'h7F, 8'h01, 2'b00, 8'h80, 1'b1);
        run_ovf("ovf_sub", 8'h80, 8'h01, 2'b01, 8'h7F, 1'b1);
        run_ovf("ovf_or",  8'h7F, 8'h01, 2'b11, 8'h7F, 1'b0);
        run_ovf("ovf_add_none", 8'h10, 8'h20, 2'b00, 8'h30, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
